// File: rtl/afifo_wr_arbiter.sv
// Async FIFO write-side controller: round-robin arbitration across NREQ requesters, write pointer and full/free tracking.
// Optional packet lock is enabled by defining AFIFO_WR_ARB_PKT_LOCK_EN, which adds the req_last input.
module afifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int SYNC_STG = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
    input  logic [NREQ-1:0]          req_last,
`endif
    output logic [NREQ-1:0]          req_ready,
    input  logic [ADDR_W:0]          rd_gray,
    output logic [ADDR_W:0]          wr_gray,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     full,
    output logic [ADDR_W:0]          free_cnt,
    output logic [$clog2(NREQ)-1:0]  grant_id
);
    localparam int PW  = ADDR_W + 1;
    localparam int IDW = $clog2(NREQ);
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [SYNC_STG-1:0][PW-1:0] rd_sync_q;
    logic [PW-1:0]     wr_bin_q, wr_bin_d, wr_gray_q, rd_bin, used;
    logic [IDW-1:0]    last_grant_q, grant_id_q, winner;
    logic              mem_we_q, found, accept;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [DATA_W-1:0] mem_wdata_q;
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
    logic              lock_q;
`endif

    // Occupancy is measured against a possibly stale read pointer, so it can only overstate.
    assign rd_bin   = gray2bin(rd_sync_q[SYNC_STG-1]);
    assign used     = wr_bin_q - rd_bin;
    assign free_cnt = DEPTH - used;
    assign full     = (free_cnt == '0);
    assign wr_bin_d = wr_bin_q + 1'b1;

    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
        if (lock_q) begin
            found  = req_valid[last_grant_q];
            winner = last_grant_q;
        end
`endif
    end

    assign accept    = found && !full;
    assign req_ready = accept ? (NREQ'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync_q    <= '0;
            wr_bin_q     <= '0;
            wr_gray_q    <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            grant_id_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            rd_sync_q <= {rd_sync_q[SYNC_STG-2:0], rd_gray};
            // Gray follows binary by one edge so it publishes only slots the RAM already holds.
            wr_gray_q <= wr_bin_q ^ (wr_bin_q >> 1);
            mem_we_q  <= accept;
            if (accept) begin
                wr_bin_q     <= wr_bin_d;
                last_grant_q <= winner;
                grant_id_q   <= winner;
                mem_waddr_q  <= wr_bin_q[ADDR_W-1:0];
                mem_wdata_q  <= req_data[int'(winner)*DATA_W +: DATA_W];
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
                lock_q       <= !req_last[winner];
`endif
            end
        end
    end

    assign wr_gray   = wr_gray_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_id_q;
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Randomised bench for afifo_wr_arbiter against an unwrapped-count reference model with a delayed read view.
module tb_afifo_wr_arbiter;
    localparam int NREQ = 4, DATA_W = 32, ADDR_W = 4, SYNC_STG = 2;
    localparam int DEPTH = 1 << ADDR_W;

    logic                   clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0, req_ready;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [ADDR_W:0]        rd_gray = '0, wr_gray, free_cnt;
    logic                   mem_we, full;
    logic [ADDR_W-1:0]      mem_waddr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [1:0]             grant_id;
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
    logic [NREQ-1:0]        req_last = '0;
`endif

    afifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STG(SYNC_STG)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
        .req_last(req_last),
`endif
        .req_ready(req_ready), .rd_gray(rd_gray), .wr_gray(wr_gray), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .full(full), .free_cnt(free_cnt),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    // Model state: unwrapped write/read counts and the values the DUT's registers should hold.
    int wr_cnt, rd_cnt, last, rd_q[$];
    bit exp_we, lk;
    int exp_waddr, exp_gid, exp_wgray;
    logic [DATA_W-1:0] exp_wdata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int gray(input int x);
        int y;
        y = x % (2 * DEPTH);
        return y ^ (y >> 1);
    endfunction

    task automatic model_reset();
        wr_cnt = 0; rd_cnt = 0; last = NREQ - 1; lk = 0;
        exp_we = 0; exp_waddr = 0; exp_gid = 0; exp_wgray = 0; exp_wdata = '0;
        rd_q.delete();
        for (int i = 0; i < SYNC_STG; i++) rd_q.push_back(0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rd_gray = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_free", free_cnt, DEPTH);
        check("rst_full", full, 0);
        check("rst_wgray", wr_gray, 0);
        check("rst_ready", req_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_gid", grant_id, 0);
    endtask

    task automatic step(input logic [NREQ-1:0] v);
        int used, win;
        logic [NREQ-1:0] er;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
        req_last = NREQ'($urandom);
`endif
        rd_gray = (ADDR_W+1)'(gray(rd_cnt));
        #1;
        used = wr_cnt - rd_q[0];
        win = -1;
        if (lk) begin
            if (v[last]) win = last;
        end else begin
            for (int k = 1; k <= NREQ && win < 0; k++)
                if (v[(last + k) % NREQ]) win = (last + k) % NREQ;
        end
        er = (win >= 0 && used < DEPTH) ? NREQ'(1 << win) : '0;
        check("free_cnt", free_cnt, DEPTH - used);
        check("full", full, used == DEPTH);
        check("req_ready", req_ready, er);
        check("mem_we", mem_we, exp_we);
        check("mem_waddr", mem_waddr, exp_waddr);
        check("mem_wdata", mem_wdata, exp_wdata);
        check("grant_id", grant_id, exp_gid);
        check("wr_gray", wr_gray, exp_wgray);
        exp_wgray = gray(wr_cnt);
        rd_q.push_back(rd_cnt);
        void'(rd_q.pop_front());
        if (er != '0) begin
            exp_we = 1; exp_waddr = wr_cnt % DEPTH; exp_gid = win; last = win;
            exp_wdata = req_data[win*DATA_W +: DATA_W];
            wr_cnt++;
`ifdef AFIFO_WR_ARB_PKT_LOCK_EN
            lk = !req_last[win];
`endif
        end else begin
            exp_we = 0;
        end
    endtask

    initial begin
        do_reset();
        // Fill with every requester asking and the reader parked at 0.
        repeat (20) step('1);
        check("fill_full", full, 1);
        check("fill_wgray", wr_gray, 5'b11000);
        check("fill_ready", req_ready, 0);
        // Reader frees three slots: exactly three more beats go in.
        rd_cnt = 3;
        repeat (8) step('1);
        check("drain3_wgray", wr_gray, 5'b11010);
        check("drain3_full", full, 1);
        // Random traffic with the reader trailing; pointers wrap several times.
        for (int c = 0; c < 300; c++) begin
            if (rd_cnt < wr_cnt && ($urandom % 3) != 0) rd_cnt++;
            step(NREQ'($urandom));
        end
        // Requester 2 alone, valid on alternate cycles.
        for (int c = 0; c < 24; c++) begin
            if (rd_cnt < wr_cnt) rd_cnt++;
            step((c % 2) ? NREQ'(4) : NREQ'(0));
        end
        // Reset in the middle of a burst, then more random traffic.
        repeat (6) step('1);
        do_reset();
        for (int c = 0; c < 120; c++) begin
            if (rd_cnt < wr_cnt && ($urandom % 2) != 0) rd_cnt++;
            step(NREQ'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
